hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_if.sv | 44 ++++
 rtl/hazard_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/hazard_unit_if.sv
// Purpose: bundle of pipeline-hazard signals between the datapath and hazard_unit.
// Latency: none; plain wires, no storage.
// Backpressure: none carried here; stall/flush outputs are the pipeline's backpressure.
//
// Ports (as seen from the hazard unit, modport slave):
//   in : IFID_rs1, IFID_rs2, IFID_Uses_rs2  decode-stage source registers
//   in : IDEX_rd, IDEX_MemRead              destination / load flag of the EX instruction
//   in : Branch_Taken                       taken branch resolved in EX/MEM
//   in : Counters_Clear                     clear for the performance counters
//   out: PC_Write, IFID_Write               hold controls
//   out: IFID_Flush, IDEX_Flush, EXMEM_Flush bubble/flush controls
//   out: Stall_Count, Flush_Count           saturating performance counters
// The master modport is the pipeline side (drives the inputs, consumes the controls).
interface hazard_unit_if;
  logic [4:0]  IFID_rs1;
  logic [4:0]  IFID_rs2;
  logic        IFID_Uses_rs2;
  logic [4:0]  IDEX_rd;
  logic        IDEX_MemRead;
  logic        Branch_Taken;
  logic        Counters_Clear;

  logic        PC_Write;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Flush;
  logic        EXMEM_Flush;
  logic [31:0] Stall_Count;
  logic [31:0] Flush_Count;

  modport master (
    output IFID_rs1, IFID_rs2, IFID_Uses_rs2, IDEX_rd, IDEX_MemRead,
           Branch_Taken, Counters_Clear,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
           Stall_Count, Flush_Count
  );

  modport slave (
    input  IFID_rs1, IFID_rs2, IFID_Uses_rs2, IDEX_rd, IDEX_MemRead,
           Branch_Taken, Counters_Clear,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
           Stall_Count, Flush_Count
  );
endinterface

// File: rtl/hazard_unit.sv
// Purpose: load-use stall and taken-branch flush control for a 5-stage pipeline, plus event counters.
// Latency: control outputs are combinational (same cycle); counters update on the next clk edge.
// Backpressure: a load-use hazard holds PC and IF/ID for exactly one cycle and bubbles ID/EX.
//
// Ports:
//   clk    pipeline clock (rising edge)
//   reset  synchronous active-high reset: FSM to RUN, counters to zero
//   hif    hazard_unit_if.slave - hazard inputs, pipeline controls, counters
module hazard_unit (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  hif
);

  // RUN: normal issue. LU_STALL: the cycle right after a load-use bubble was
  // inserted; the load has moved on to MEM so the same comparison would be
  // stale, which is why load_use is masked here.
  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic        rs1_match;
  logic        rs2_match;
  logic        load_use;
  logic        stall_now;
  logic        flush_now;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;

  // ------------------------------------------------------------------
  // Hazard detection
  // ------------------------------------------------------------------
  // x0 is hard-wired zero, so a load targeting it can never feed a consumer;
  // the rd != 0 term keeps rs1/rs2 == 0 from matching it.
  assign rs1_match = (hif.IDEX_rd == hif.IFID_rs1);
  assign rs2_match = hif.IFID_Uses_rs2 && (hif.IDEX_rd == hif.IFID_rs2);
  assign load_use  = hif.IDEX_MemRead && (hif.IDEX_rd != 5'd0) && (rs1_match || rs2_match);

  // A taken branch squashes the decode instruction anyway, so it wins over
  // load_use; reset masks both so the pipeline runs freely while held.
  assign flush_now = !reset && hif.Branch_Taken;
  assign stall_now = !reset && !hif.Branch_Taken && (state == RUN) && load_use;

  // ------------------------------------------------------------------
  // Control outputs (combinational from state and current inputs)
  // ------------------------------------------------------------------
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    if (flush_now) begin
      // Kill the three younger instructions fetched down the wrong path;
      // PC keeps writing so the branch target is loaded.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (stall_now) begin
      // Freeze fetch/decode and send a bubble into EX for one cycle.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  assign hif.PC_Write    = pc_write;
  assign hif.IFID_Write  = ifid_write;
  assign hif.IFID_Flush  = ifid_flush;
  assign hif.IDEX_Flush  = idex_flush;
  assign hif.EXMEM_Flush = exmem_flush;

  // ------------------------------------------------------------------
  // State and counters
  // ------------------------------------------------------------------
  // Every stall moves to LU_STALL and LU_STALL always returns to RUN, so a
  // single load can never cost more than one bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      state <= stall_now ? LU_STALL : RUN;

      // Clear takes precedence over a same-cycle increment.
      if (hif.Counters_Clear) begin
        stall_cnt <= 32'd0;
        flush_cnt <= 32'd0;
      end else begin
        // Saturate at all-ones rather than wrapping to zero.
        if (stall_now && (stall_cnt != 32'hFFFF_FFFF)) begin
          stall_cnt <= stall_cnt + 32'd1;
        end
        if (flush_now && (flush_cnt != 32'hFFFF_FFFF)) begin
          flush_cnt <= flush_cnt + 32'd1;
        end
      end
    end
  end

  assign hif.Stall_Count = stall_cnt;
  assign hif.Flush_Count = flush_cnt;

endmodule
